// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte streams.
// Grant is held from a packet's first byte through its last byte.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           uart_data,
  output logic                 uart_start,
  input  logic                 uart_busy,
  output logic [IDX_W-1:0]     grant_id,
  output logic                 locked,
  output logic [15:0]          pkt_count
);

  typedef enum logic [1:0] {ARB, START, WAIT_BUSY, WAIT_DONE} state_t;

  localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] rr_ptr, winner, rr_nxt;
  logic             win_found, accept, sel_last;
  logic [7:0]       sel_byte;

  // Locked: only the holder is eligible. Otherwise scan from rr_ptr, wrapping.
  always_comb begin : select
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;
    win_found = 1'b0;
    winner    = grant_id;
    sum       = '0;
    cand      = '0;
    if (locked) begin
      win_found = req_valid[grant_id];
    end else begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        sum  = {1'b0, rr_ptr} + (IDX_W+1)'(k);
        cand = (sum >= NUM_REQ_W) ? IDX_W'(sum - NUM_REQ_W) : IDX_W'(sum);
        if (!win_found && req_valid[cand]) begin
          win_found = 1'b1;
          winner    = cand;
        end
      end
    end
  end

  always_comb begin
    sel_byte = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (IDX_W'(k) == winner) sel_byte = req_data[8*k +: 8];
    end
  end

  assign sel_last = req_last[winner];
  assign accept   = (state == ARB) && win_found;
  assign rr_nxt   = (winner == LAST_IDX) ? '0 : winner + 1'b1;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[winner] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB:       if (accept)     state_nxt = START;
      START:                     state_nxt = WAIT_BUSY;
      WAIT_BUSY: if (uart_busy)  state_nxt = WAIT_DONE;
      WAIT_DONE: if (!uart_busy) state_nxt = ARB;
      default:                   state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ARB;
      rr_ptr     <= '0;
      uart_data  <= '0;
      uart_start <= 1'b0;
      grant_id   <= '0;
      locked     <= 1'b0;
      pkt_count  <= '0;
    end else begin
      state      <= state_nxt;
      uart_start <= accept;
      if (accept) begin
        uart_data <= sel_byte;
        grant_id  <= winner;
        if (sel_last) begin
          locked    <= 1'b0;
          rr_ptr    <= rr_nxt;
          pkt_count <= pkt_count + 16'd1;
        end else begin
          locked <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural uart_tx busy model.
module tb_uart_tx_arbiter;
  localparam int N     = 4;
  localparam int FRAME = 40;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]  req_last = '0;
  logic [N-1:0]  req_ready;
  logic [7:0]    uart_data;
  logic          uart_start;
  logic          uart_busy;
  logic [1:0]    grant_id;
  logic          locked;
  logic [15:0]   pkt_count;

  int total = 0;
  int bad   = 0;
  int t = 0;
  int delay_cfg = 0;
  logic [7:0] sent[$];
  logic [7:0] exp_d[$];
  int         got_g[$];
  int         exp_g[$];
  logic [7:0] pd[N][8];
  logic       pl[N][8];
  int         plen[N];
  int         ppos[N];

  uart_tx_arbiter #(.NUM_REQ(N), .IDX_W(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .uart_data(uart_data), .uart_start(uart_start),
    .uart_busy(uart_busy), .grant_id(grant_id), .locked(locked),
    .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  // uart_tx stand-in: busy low for delay_cfg cycles after start, then high FRAME cycles.
  always @(posedge clk) begin
    if (uart_start) begin
      sent.push_back(uart_data);
      t <= 1;
    end else if (t != 0) begin
      t <= (t >= delay_cfg + FRAME) ? 0 : t + 1;
    end
  end
  assign uart_busy = (t > delay_cfg) && (t <= delay_cfg + FRAME);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    req_valid = '0;
    req_last  = '0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    sent.delete();
  endtask

  task automatic send(input int i, input logic [7:0] d, input logic l);
    int n = 0;
    req_valid[i] = 1'b1;
    req_data[8*i +: 8] = d;
    req_last[i] = l;
    #1;
    while (req_ready[i] !== 1'b1 && n < 2000) begin
      @(posedge clk); #2; n++;
    end
    check("ready", 32'(req_ready), 32'(1 << i));
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    check("start", 32'(uart_start), 32'd1);
    check("data", 32'(uart_data), 32'(d));
    check("grant", 32'(grant_id), 32'(i));
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((t != 0 || uart_busy) && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    check("idle_timeout", 32'(n < 2000), 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run_traffic(input int budget);
    int n = 0;
    int multi = 0;
    int idx;
    bit done = 0;
    got_g.delete();
    for (int i = 0; i < N; i++) ppos[i] = 0;
    while (!done && n < budget) begin
      for (int i = 0; i < N; i++) begin
        req_valid[i] = (ppos[i] < plen[i]);
        if (ppos[i] < plen[i]) begin
          req_data[8*i +: 8] = pd[i][ppos[i]];
          req_last[i] = pl[i][ppos[i]];
        end
      end
      #1;
      if ($countones(req_ready) > 1) multi++;
      idx = -1;
      for (int i = 0; i < N; i++) if (req_ready[i]) idx = i;
      if (idx >= 0) begin
        got_g.push_back(idx);
        ppos[idx]++;
      end
      done = 1;
      for (int i = 0; i < N; i++) if (ppos[i] < plen[i]) done = 0;
      @(posedge clk); #1; n++;
    end
    req_valid = '0;
    check("traffic_timeout", 32'(done), 32'd1);
    check("ready_onehot", 32'(multi), 32'd0);
  endtask

  task automatic check_logs(input string tag, input bit with_grants);
    check({tag, "_sent_n"}, 32'(sent.size()), 32'(exp_d.size()));
    for (int k = 0; k < exp_d.size(); k++)
      check({tag, "_sent"}, (k < sent.size()) ? 32'(sent[k]) : 32'hDEAD, 32'(exp_d[k]));
    if (with_grants) begin
      check({tag, "_grant_n"}, 32'(got_g.size()), 32'(exp_g.size()));
      for (int k = 0; k < exp_g.size(); k++)
        check({tag, "_grant"}, (k < got_g.size()) ? 32'(got_g[k]) : 32'hDEAD, 32'(exp_g[k]));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rdy;
    int st;

    // reset values
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_data", 32'(uart_data), 32'd0);
    check("rst_start", 32'(uart_start), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_pkt", 32'(pkt_count), 32'd0);
    reset = 1'b1;
    sent.delete();

    // single source, two-byte packet
    send(0, 8'h55, 1'b0);
    check("t1_locked_mid", 32'(locked), 32'd1);
    send(0, 8'hA3, 1'b1);
    check("t1_locked_end", 32'(locked), 32'd0);
    check("t1_pkt", 32'(pkt_count), 32'd1);
    @(posedge clk); #1;
    check("t1_start_pulse", 32'(uart_start), 32'd0);
    check("t1_data_stable", 32'(uart_data), 32'hA3);
    wait_idle();
    exp_d = '{8'h55, 8'hA3};
    check_logs("t1", 1'b0);

    // contention: req1 and req2 with 3-byte packets
    do_reset();
    for (int i = 0; i < N; i++) plen[i] = 0;
    plen[1] = 3; plen[2] = 3;
    pd[1][0] = 8'h11; pd[1][1] = 8'h12; pd[1][2] = 8'h13;
    pd[2][0] = 8'h21; pd[2][1] = 8'h22; pd[2][2] = 8'h23;
    for (int k = 0; k < 3; k++) begin
      pl[1][k] = (k == 2);
      pl[2][k] = (k == 2);
    end
    run_traffic(2000);
    wait_idle();
    exp_d = '{8'h11, 8'h12, 8'h13, 8'h21, 8'h22, 8'h23};
    exp_g = '{1, 1, 1, 2, 2, 2};
    check_logs("t2", 1'b1);
    check("t2_pkt", 32'(pkt_count), 32'd2);

    // fairness: everyone offers single-byte packets
    do_reset();
    for (int i = 0; i < N; i++) begin
      plen[i] = 2;
      for (int k = 0; k < 2; k++) begin
        pd[i][k] = 8'hC0 + 8'(i);
        pl[i][k] = 1'b1;
      end
    end
    run_traffic(2000);
    wait_idle();
    exp_d = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC0, 8'hC1, 8'hC2, 8'hC3};
    exp_g = '{0, 1, 2, 3, 0, 1, 2, 3};
    check_logs("t3", 1'b1);
    check("t3_pkt", 32'(pkt_count), 32'd8);

    // lock stall: holder goes quiet, req3 must starve
    do_reset();
    send(0, 8'h01, 1'b0);
    req_valid[3] = 1'b1;
    req_data[31:24] = 8'h33;
    req_last[3] = 1'b1;
    @(posedge clk); #1;
    rdy = 0; st = 0;
    for (int c = 0; c < 50; c++) begin
      if (req_ready != '0) rdy++;
      if (uart_start) st++;
      @(posedge clk); #1;
    end
    check("t4_no_ready", 32'(rdy), 32'd0);
    check("t4_no_start", 32'(st), 32'd0);
    check("t4_locked", 32'(locked), 32'd1);
    send(0, 8'h02, 1'b1);
    send(3, 8'h33, 1'b1);
    wait_idle();
    exp_d = '{8'h01, 8'h02, 8'h33};
    check_logs("t4", 1'b0);

    // delayed busy: no acceptance until busy has risen and fallen
    do_reset();
    delay_cfg = 5;
    send(1, 8'h5A, 1'b1);
    req_valid[2] = 1'b1;
    req_data[23:16] = 8'h77;
    req_last[2] = 1'b1;
    @(posedge clk); #1;
    rdy = 0; st = 0;
    for (int c = 0; c < 5 + FRAME + 1; c++) begin
      if (req_ready != '0) rdy++;
      if (uart_start) st++;
      @(posedge clk); #1;
    end
    check("t5_no_ready", 32'(rdy), 32'd0);
    check("t5_no_start", 32'(st), 32'd0);
    check("t5_ready_now", 32'(req_ready), 32'b0100);
    send(2, 8'h77, 1'b1);
    delay_cfg = 0;
    wait_idle();
    exp_d = '{8'h5A, 8'h77};
    check_logs("t5", 1'b0);

    // reset while in WAIT_DONE with a packet open
    do_reset();
    send(0, 8'hA0, 1'b1); wait_idle();
    send(0, 8'hA1, 1'b1); wait_idle();
    send(0, 8'hA2, 1'b1); wait_idle();
    send(1, 8'hB0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("t6_pre_locked", 32'(locked), 32'd1);
    check("t6_pre_pkt", 32'(pkt_count), 32'd3);
    check("t6_pre_busy", 32'(uart_busy), 32'd1);
    reset = 1'b0;
    #1;
    check("t6_data", 32'(uart_data), 32'd0);
    check("t6_start", 32'(uart_start), 32'd0);
    check("t6_grant", 32'(grant_id), 32'd0);
    check("t6_locked", 32'(locked), 32'd0);
    check("t6_pkt", 32'(pkt_count), 32'd0);
    check("t6_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    req_valid[3] = 1'b1;
    req_data[31:24] = 8'hD3;
    req_last[3] = 1'b1;
    send(2, 8'hC2, 1'b1);
    req_valid[3] = 1'b0;
    wait_idle();

    // pkt_count wrap
    do_reset();
    force dut.pkt_count = 16'hFFFE;
    #1;
    release dut.pkt_count;
    send(3, 8'hE1, 1'b1);
    check("t7_pkt_ffff", 32'(pkt_count), 32'hFFFF);
    wait_idle();
    send(3, 8'hE2, 1'b1);
    check("t7_pkt_wrap", 32'(pkt_count), 32'd0);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares one uart_tx serializer between NUM_REQ byte-stream requesters.
- Each requester offers bytes with a valid/ready handshake and marks packet end with last.
- Grant is held for a whole packet, so frames from different sources never interleave on the line.
- Sits between the protocol engines (header/data/ack senders) and uart_tx; drives its tx_data/tx_start and watches tx_busy.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IDX_W, 2, width of the grant index; must be ≥ clog2(NUM_REQ).

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  requester i has a byte on req_data slice i.
- req_data  input  8*NUM_REQ  byte for requester i at bits [8i+7:8i].
- req_last  input  NUM_REQ  byte offered by requester i ends its packet.
- req_ready  output  NUM_REQ  combinational; one-hot or zero; byte accepted on this edge when valid&ready.
- uart_data  output  8  byte to uart_tx tx_data; registered.
- uart_start  output  1  one-cycle start pulse to uart_tx tx_start; registered.
- uart_busy  input  1  tx_busy from uart_tx.
- grant_id  output  IDX_W  index of the current/last granted requester.
- locked  output  1  a packet is in progress (grant held).
- pkt_count  output  16  count of completed packets, wraps 0xFFFF→0.

Behaviour:
- Reset values: req_ready=0, uart_data=0x00, uart_start=0, grant_id=0, locked=0, pkt_count=0; internal rr_ptr=0; state=ARB.
- Reset mid-byte: all of the above clear immediately. An in-flight uart_tx frame is not aborted by this block. After reset the block waits in ARB and ignores uart_busy until it issues its own start.
- States: ARB, START, WAIT_BUSY, WAIT_DONE.
- ARB, selection:
  - If locked=1, only requester grant_id is eligible.
  - Otherwise the winner is the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - req_ready[winner]=1 only in ARB; all other bits 0. No eligible valid → req_ready=0, stay in ARB.
- ARB, on acceptance (valid & ready):
  - uart_data ← that byte; grant_id ← winner; go to START.
  - If req_last=1: locked ← 0, rr_ptr ← (winner+1) mod NUM_REQ, pkt_count ← pkt_count+1.
  - Else: locked ← 1.
- START: uart_start=1 for exactly this one cycle; go to WAIT_BUSY.
- WAIT_BUSY: stay until uart_busy=1, then go to WAIT_DONE. uart_tx raises busy the cycle after start.
- WAIT_DONE: stay until uart_busy=0, then go to ARB.
- uart_data is stable from START through WAIT_DONE.
- Throughput: acceptance-to-start latency is 1 cycle. Start-to-next-acceptance is frame length + 2 cycles (10·CLKS_PER_BIT + 2).
- Locked requester with valid=0: the arbiter waits indefinitely; other requesters starve by design (packet atomicity).
- Single-byte packet (valid with last on first byte): no lock; pointer advances.
- A requester dropping valid without acceptance is legal; no byte is consumed.
- req_data/req_last are sampled only on the acceptance edge.

Test Plan:
- Single source: req0 sends 0x55,0xA3(last) with uart_tx at CLKS_PER_BIT=4.
  → two starts, each 1 cycle after its req_ready; line shows both frames in order; pkt_count=1; locked 1 then 0.
- Contention: req1 and req2 both valid from reset with 3-byte packets 0x11,0x12,0x13 and 0x21,0x22,0x23.
  → req1 wins (rr_ptr=0, first valid at index 1); line order 11,12,13,21,22,23; req2 gets no ready until req1's last is accepted.
- Fairness: all 4 requesters continuously offer 1-byte packets (value = 0xC0+i).
  → grant_id sequence 0,1,2,3,0,1…; each byte transmitted once.
- Lock stall: req0 sends 0x01 (not last), then drops valid for 50 cycles while req3 is valid.
  → req3 never readied; uart_start stays 0; req0 resumes with 0x02(last) → sent, then req3 served.
- Handshake timing: uart_busy held low by the bench model for 5 cycles after start.
  → FSM stays in WAIT_BUSY; no second start; proceeds only after busy rises then falls.
- Reset in WAIT_DONE with locked=1, pkt_count=3.
  → all outputs zero, locked=0, pkt_count=0; the next valid requester ≥0 is granted after release.
- Wrap: preload via 65536 single-byte packets (or force) → pkt_count returns to 0.
